cook_timer: RTL and testbench

Countdown timer that sits directly downstream of the microwave controller FSM. It consumes the controller's `Heat` (start) and `Close` (door) outputs and produces the `done` pulse the controller waits on to leave the cooking state. Cook time is held as minutes:seconds, counts down once per prescaled tick, and is exported both in binary and as four BCD digits for the display.

---
 rtl/microwave_pkg.sv | 23 ++
 rtl/bin2bcd_99.sv | 18 +
 rtl/cook_timer.sv | 135 +++++++++++++
 tb/tb_cook_timer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types, limits and clamp helpers for the microwave timer path
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int MIN_W   = 7;
  localparam int SEC_W   = 6;
  localparam int MIN_MAX = 99;
  localparam int SEC_MAX = 59;

  function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v);
    return (v > MIN_W'(MIN_MAX)) ? MIN_W'(MIN_MAX) : v;
  endfunction

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] v);
    return (v > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : v;
  endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// rtl/bin2bcd_99.sv - converts a binary value 0-99 to two BCD digits
module bin2bcd_99 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] q;
  logic [6:0] r;

  always_comb begin
    q    = bin / 7'd10;
    r    = bin % 7'd10;
    tens = q[3:0];
    ones = r[3:0];
  end

endmodule

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - mm:ss countdown timer driven by the controller Heat/Close outputs
module cook_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 100
) (
  input  logic             clk,
  input  logic             sys_reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  input  logic             Heat,
  input  logic             Close,
  output logic             done,
  output logic             running,
  output logic [MIN_W-1:0] rem_min,
  output logic [SEC_W-1:0] rem_sec,
  output logic [15:0]      bcd
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] WRAP = PW'(TICK_DIV - 1);

  state_t           state, state_n;
  logic [MIN_W-1:0] min_q, min_n;
  logic [SEC_W-1:0] sec_q, sec_n;
  logic [PW-1:0]    presc, presc_n;
  logic             done_q, done_n;

  logic [MIN_W-1:0] cmin;
  logic [SEC_W-1:0] csec;
  logic             load_zero;
  logic             tick;
  logic             last_sec;

  always_ff @(posedge clk) begin
    if (!sys_reset_n) begin
      state  <= IDLE;
      min_q  <= '0;
      sec_q  <= '0;
      presc  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      min_q  <= min_n;
      sec_q  <= sec_n;
      presc  <= presc_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    cmin      = clamp_min(load_min);
    csec      = clamp_sec(load_sec);
    load_zero = (cmin == '0) && (csec == '0);
    tick      = (presc == WRAP);
    last_sec  = (min_q == '0) && (sec_q == SEC_W'(1));

    state_n = state;
    min_n   = min_q;
    sec_n   = sec_q;
    presc_n = presc;
    done_n  = 1'b0;

    if (clear) begin
      state_n = IDLE;
      min_n   = '0;
      sec_n   = '0;
      presc_n = '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (load) begin
            min_n   = cmin;
            sec_n   = csec;
            state_n = load_zero ? IDLE : READY;
          end else if (Heat) begin
            // Heat in IDLE releases the controller immediately instead of hanging it
            if (state == IDLE) begin
              done_n = 1'b1;
            end else if (Close) begin
              state_n = RUN;
              presc_n = '0;
            end
          end
        end
        RUN: begin
          if (!Close) begin
            state_n = READY;
            presc_n = '0;
          end else if (tick) begin
            presc_n = '0;
            if (sec_q == '0) begin
              sec_n = SEC_W'(SEC_MAX);
              min_n = min_q - MIN_W'(1);
            end else begin
              sec_n = sec_q - SEC_W'(1);
            end
            if (last_sec) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          min_n   = '0;
          sec_n   = '0;
          presc_n = '0;
        end
      endcase
    end
  end

  assign done    = done_q;
  assign running = (state == RUN);
  assign rem_min = min_q;
  assign rem_sec = sec_q;

  bin2bcd_99 u_min_bcd (
    .bin  (min_q),
    .tens (bcd[15:12]),
    .ones (bcd[11:8])
  );

  bin2bcd_99 u_sec_bcd (
    .bin  ({1'b0, sec_q}),
    .tens (bcd[7:4]),
    .ones (bcd[3:0])
  );

endmodule

// File: tb/tb_cook_timer.sv
// tb/tb_cook_timer.sv - self-checking bench for cook_timer with TICK_DIV=4
module tb_cook_timer;

  logic        clk;
  logic        sys_reset_n;
  logic        clear;
  logic        load;
  logic [6:0]  load_min;
  logic [5:0]  load_sec;
  logic        Heat;
  logic        Close;
  logic        done;
  logic        running;
  logic [6:0]  rem_min;
  logic [5:0]  rem_sec;
  logic [15:0] bcd;

  int passed = 0;
  int total  = 0;

  cook_timer #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .sys_reset_n (sys_reset_n),
    .clear       (clear),
    .load        (load),
    .load_min    (load_min),
    .load_sec    (load_sec),
    .Heat        (Heat),
    .Close       (Close),
    .done        (done),
    .running     (running),
    .rem_min     (rem_min),
    .rem_sec     (rem_sec),
    .bcd         (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       ld;
    logic [6:0] lm;
    logic [5:0] ls;
    logic       ht;
    logic       cl;
    logic       e_done;
    logic       e_run;
    logic [6:0] e_min;
    logic [5:0] e_sec;
  } vec_t;

  vec_t exp_q[$];

  function automatic vec_t mk(string n, int clr, int ld, int lm, int ls, int ht, int cl,
                              int ed, int er, int em, int es);
    vec_t v;
    v.name = n;       v.clr = clr[0]; v.ld = ld[0];
    v.lm = lm[6:0];   v.ls = ls[5:0]; v.ht = ht[0]; v.cl = cl[0];
    v.e_done = ed[0]; v.e_run = er[0]; v.e_min = em[6:0]; v.e_sec = es[5:0];
    return v;
  endfunction

  function automatic logic [15:0] exp_bcd(int m, int s);
    logic [15:0] r;
    r[15:12] = 4'(m / 10);
    r[11:8]  = 4'(m % 10);
    r[7:4]   = 4'(s / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic step(vec_t v);
    vec_t e;
    clear = v.clr; load = v.ld; load_min = v.lm; load_sec = v.ls;
    Heat = v.ht;   Close = v.cl;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.name, ".done"},    int'(done),    int'(e.e_done));
    chk({e.name, ".running"}, int'(running), int'(e.e_run));
    chk({e.name, ".min"},     int'(rem_min), int'(e.e_min));
    chk({e.name, ".sec"},     int'(rem_sec), int'(e.e_sec));
    chk({e.name, ".bcd"},     int'(bcd),     int'(exp_bcd(int'(e.e_min), int'(e.e_sec))));
  endtask

  vec_t tbl[16];

  initial begin
    int m, s;
    sys_reset_n = 1'b0;
    clear = 0; load = 0; load_min = 0; load_sec = 0; Heat = 0; Close = 1;

    // reset dominates load and Heat
    step(mk("rst0", 0, 1, 5, 5, 1, 1, 0, 0, 0, 0));
    step(mk("rst1", 0, 1, 5, 5, 1, 1, 0, 0, 0, 0));
    sys_reset_n = 1'b1;

    //             name       clr ld lm   ls ht cl  done run min sec
    tbl[0]  = mk("clamp",     0, 1, 120, 63, 0, 1, 0, 0, 99, 59);
    tbl[1]  = mk("ld_zero",   0, 1, 0,   0,  0, 1, 0, 0, 0,  0);
    tbl[2]  = mk("idle_heat", 0, 0, 0,   0,  1, 1, 1, 0, 0,  0);
    tbl[3]  = mk("done_1cyc", 0, 0, 0,   0,  0, 1, 0, 0, 0,  0);
    tbl[4]  = mk("ld_1_00",   0, 1, 1,   0,  0, 1, 0, 0, 1,  0);
    tbl[5]  = mk("ld_heat",   0, 1, 5,   5,  1, 1, 0, 0, 5,  5);
    tbl[6]  = mk("ld_heat2",  0, 0, 0,   0,  0, 1, 0, 0, 5,  5);
    tbl[7]  = mk("heat_open", 0, 0, 0,   0,  1, 0, 0, 0, 5,  5);
    tbl[8]  = mk("ld_10_00",  0, 1, 10,  0,  0, 1, 0, 0, 10, 0);
    tbl[9]  = mk("start10",   0, 0, 0,   0,  1, 1, 0, 1, 10, 0);
    tbl[10] = mk("run_p1",    0, 0, 0,   0,  0, 1, 0, 1, 10, 0);
    tbl[11] = mk("run_p2",    0, 0, 0,   0,  0, 1, 0, 1, 10, 0);
    tbl[12] = mk("run_p3",    0, 0, 0,   0,  0, 1, 0, 1, 10, 0);
    tbl[13] = mk("borrow10",  0, 0, 0,   0,  0, 1, 0, 1, 9,  59);
    tbl[14] = mk("ld_in_run", 0, 1, 3,   3,  1, 1, 0, 1, 9,  59);
    tbl[15] = mk("clear_run", 1, 0, 0,   0,  0, 1, 0, 0, 0,  0);
    foreach (tbl[i]) step(tbl[i]);

    // 00:02 countdown: start in cycle t, check t+1 .. t+10
    step(mk("ld_0_02", 0, 1, 0, 2, 0, 1, 0, 0, 0, 2));
    step(mk("go2", 0, 0, 0, 0, 1, 1, 0, 1, 0, 2));
    for (int k = 2; k <= 10; k++) begin
      s = (k < 5) ? 2 : (k < 9) ? 1 : 0;
      step(mk($sformatf("cnt2_t%0d", k), 0, 0, 0, 0, 0, 1,
              (k == 9) ? 1 : 0, (k < 9) ? 1 : 0, 0, s));
    end

    // borrow 01:00 -> 00:59
    step(mk("ld_1_00b", 0, 1, 1, 0, 0, 1, 0, 0, 1, 0));
    step(mk("go1m", 0, 0, 0, 0, 1, 1, 0, 1, 1, 0));
    for (int k = 2; k <= 5; k++) begin
      m = (k < 5) ? 1 : 0;
      s = (k < 5) ? 0 : 59;
      step(mk($sformatf("b1m_t%0d", k), 0, 0, 0, 0, 0, 1, 0, 1, m, s));
    end
    step(mk("b1m_clr", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // door abort at t+6 with 00:03 loaded, then resume
    step(mk("ld_0_03", 0, 1, 0, 3, 0, 1, 0, 0, 0, 3));
    step(mk("go3", 0, 0, 0, 0, 1, 1, 0, 1, 0, 3));
    for (int k = 2; k <= 6; k++)
      step(mk($sformatf("d3_t%0d", k), 0, 0, 0, 0, 0, 1, 0, 1, 0, (k < 5) ? 3 : 2));
    step(mk("door_open", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    for (int k = 0; k < 3; k++)
      step(mk($sformatf("door_hold%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    step(mk("resume", 0, 0, 0, 0, 1, 1, 0, 1, 0, 2));
    for (int k = 2; k <= 10; k++) begin
      s = (k < 5) ? 2 : (k < 9) ? 1 : 0;
      step(mk($sformatf("res_u%0d", k), 0, 0, 0, 0, 0, 1,
              (k == 9) ? 1 : 0, (k < 9) ? 1 : 0, 0, s));
    end

    // clear lands on the tick cycle of the last second
    step(mk("ld_0_01", 0, 1, 0, 1, 0, 1, 0, 0, 0, 1));
    step(mk("go1", 0, 0, 0, 0, 1, 1, 0, 1, 0, 1));
    for (int k = 2; k <= 4; k++)
      step(mk($sformatf("c1_t%0d", k), 0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    step(mk("clr_tick", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      step(mk($sformatf("clr_quiet%0d", k), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
